// File: rtl/serial_word_receiver_pkg.sv
// Shared state encodings and direction constants for the serial word receiver.
package serial_word_receiver_pkg;

  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_COLLECT = 1'b1
  } rx_state_e;

  typedef enum logic {
    OB_EMPTY = 1'b0,
    OB_FULL  = 1'b1
  } ob_state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/word_out_buffer.sv
// One-entry valid/ready holding register; a word arriving while full and not
// being drained is dropped and recorded in a sticky overrun flag.
module word_out_buffer
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  ob_state_e        r_state, w_state_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic             r_overrun, w_overrun_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= OB_EMPTY;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_data    <= w_data_next;
      r_overrun <= w_overrun_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_data_next    = r_data;
    w_overrun_next = r_overrun;
    if (i_clr) begin
      w_state_next   = OB_EMPTY;
      w_data_next    = '0;
      w_overrun_next = 1'b0;
    end else begin
      case (r_state)
        OB_EMPTY: begin
          if (i_wr) begin
            w_state_next = OB_FULL;
            w_data_next  = i_wdata;
          end
        end
        OB_FULL: begin
          // A drain in the same cycle as a new word makes room for it with no gap.
          if (i_ready) begin
            if (i_wr) begin
              w_data_next = i_wdata;
            end else begin
              w_state_next = OB_EMPTY;
            end
          end else if (i_wr) begin
            w_overrun_next = 1'b1;
          end
        end
        default: w_state_next = OB_EMPTY;
      endcase
    end
  end

  assign o_data    = r_data;
  assign o_valid   = (r_state == OB_FULL);
  assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_word_receiver.sv
// Reassembles WIDTH-bit words from a serial carry-bit stream in either shift
// direction and hands them to a one-entry output buffer.
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             lsb_first,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  rx_state_e        r_rx_state, w_rx_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_sh, w_sh_next, w_shifted;
  logic             r_dir, w_dir_next, w_dir_eff, w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_dir      <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      r_cnt      <= w_cnt_next;
      r_sh       <= w_sh_next;
      r_dir      <= w_dir_next;
    end
  end

  // The first bit of a word uses the live lsb_first; later bits use the latch.
  assign w_dir_eff = (r_rx_state == RX_IDLE) ? lsb_first : r_dir;
  assign w_shifted = (w_dir_eff == DIR_LSB_FIRST) ? {bit_in, r_sh[WIDTH-1:1]}
                                                  : {r_sh[WIDTH-2:0], bit_in};

  always_comb begin
    w_rx_next  = r_rx_state;
    w_cnt_next = r_cnt;
    w_sh_next  = r_sh;
    w_dir_next = r_dir;
    w_done     = 1'b0;
    if (clr) begin
      w_rx_next  = RX_IDLE;
      w_cnt_next = '0;
      w_sh_next  = '0;
    end else if (bit_valid) begin
      w_sh_next = w_shifted;
      case (r_rx_state)
        RX_IDLE: begin
          w_dir_next = lsb_first;
          w_cnt_next = CNT_W'(1);
          w_rx_next  = RX_COLLECT;
        end
        RX_COLLECT: begin
          if (r_cnt == LAST_CNT) begin
            w_done     = 1'b1;
            w_cnt_next = '0;
            w_rx_next  = RX_IDLE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        default: w_rx_next = RX_IDLE;
      endcase
    end
  end

  word_out_buffer #(
    .WIDTH(WIDTH)
  ) u_word_out_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (clr),
    .i_wr     (w_done),
    .i_wdata  (w_shifted),
    .i_ready  (out_ready),
    .o_data   (data_out),
    .o_valid  (out_valid),
    .o_overrun(overrun)
  );

  assign busy = (r_cnt != '0);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed, table-driven check of the serial word receiver.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       lsb_first = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] data_out;
  logic       out_valid;
  logic       busy;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  serial_word_receiver #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .bit_valid(bit_valid),
    .bit_in   (bit_in),
    .lsb_first(lsb_first),
    .out_ready(out_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       c;
    logic       bv;
    logic       b;
    logic       lsb;
    logic       rdy;
    logic       ev;
    logic [3:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic c, logic bv, logic b, logic lsb, logic rdy,
                              logic ev, logic [3:0] ed, logic eb, logic eo);
    vec_t v;
    v.c = c; v.bv = bv; v.b = b; v.lsb = lsb; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo;
    return v;
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then check the state settled after the edge.
  task automatic step(string tag, vec_t v);
    @(negedge clk);
    clr = v.c; bit_valid = v.bv; bit_in = v.b; lsb_first = v.lsb; out_ready = v.rdy;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, {3'b0, out_valid}, {3'b0, v.ev});
    check({tag, ".busy"}, {3'b0, busy}, {3'b0, v.eb});
    check({tag, ".ovr"}, {3'b0, overrun}, {3'b0, v.eo});
    if (v.ev) check({tag, ".data"}, data_out, v.ed);
  endtask

  initial begin
    // LSB first 1,0,1,1 -> D
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hD,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,4'h0,0,0));
    // MSB first 1,0,gap,1,1 -> B, lsb_first toggled mid-word
    vecs.push_back(mk(0,1,1,0,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,0,0,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,0,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,0,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,0,0,0,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hB,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,4'h0,0,0));
    // Overrun: D held, 3 dropped
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hD,0,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hD,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hD,1,0));
    vecs.push_back(mk(0,1,0,1,0, 1,4'hD,1,0));
    vecs.push_back(mk(0,1,0,1,0, 1,4'hD,0,1));
    vecs.push_back(mk(0,0,0,1,1, 0,4'h0,0,1));
    // clr wipes overrun, then back-to-back A then 5
    vecs.push_back(mk(1,1,1,1,1, 0,4'h0,0,0));
    vecs.push_back(mk(0,1,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hA,0,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hA,1,0));
    vecs.push_back(mk(0,1,0,1,0, 1,4'hA,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'hA,1,0));
    vecs.push_back(mk(0,1,0,1,1, 1,4'h5,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,4'h0,0,0));
    // clr mid-word with a bit present, then 0,1,1,0 -> 6
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(1,1,1,1,0, 0,4'h0,0,0));
    vecs.push_back(mk(0,1,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 1,4'h6,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,4'h0,0,0));
    vecs.push_back(mk(0,0,0,1,1, 0,4'h0,0,0));
    // Fill with 9, drop 6 (overrun), then 2 partial bits
    vecs.push_back(mk(0,1,1,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,0,1,0, 0,4'h0,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'h9,0,0));
    vecs.push_back(mk(0,1,0,1,0, 1,4'h9,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'h9,1,0));
    vecs.push_back(mk(0,1,1,1,0, 1,4'h9,1,0));
    vecs.push_back(mk(0,1,0,1,0, 1,4'h9,0,1));
    vecs.push_back(mk(0,1,1,1,0, 1,4'h9,1,1));
    vecs.push_back(mk(0,1,1,1,0, 1,4'h9,1,1));

    // Reset state while rst_n is held low
    #12;
    check("rst.data", data_out, 4'h0);
    check("rst.valid", {3'b0, out_valid}, 4'h0);
    check("rst.busy", {3'b0, busy}, 4'h0);
    check("rst.ovr", {3'b0, overrun}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) step($sformatf("v%0d", i), vecs[i]);

    // Asynchronous reset between edges, mid-word and while full
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst.data", data_out, 4'h0);
    check("arst.valid", {3'b0, out_valid}, 4'h0);
    check("arst.busy", {3'b0, busy}, 4'h0);
    check("arst.ovr", {3'b0, overrun}, 4'h0);
    rst_n = 1'b1;

    // Fresh word after reset: LSB first 0,0,1,1 -> C
    step("post0", mk(0,1,0,1,0, 0,4'h0,1,0));
    step("post1", mk(0,1,0,1,0, 0,4'h0,1,0));
    step("post2", mk(0,1,1,1,0, 0,4'h0,1,0));
    step("post3", mk(0,1,1,1,0, 1,4'hC,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
